// File: rtl/rr_pkg.sv
// Shared reorder-buffer parameters and the per-entry record.
package rr_pkg;

    localparam int unsigned P_REGISTERS = 64;
    localparam int unsigned L_REGISTERS = 32;
    localparam int unsigned C_NUM       = 4;
    localparam int unsigned K           = 32;
    localparam int unsigned INSTR_COUNT = 2;

    localparam int unsigned ROB_DEPTH = (C_NUM - 1) * K;
    localparam int unsigned IW        = $clog2(ROB_DEPTH);
    localparam int unsigned PW        = $clog2(P_REGISTERS);
    localparam int unsigned LW        = $clog2(L_REGISTERS);
    localparam int unsigned CW        = $clog2(INSTR_COUNT + 1);

    typedef logic [IW-1:0] rob_id_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [LW-1:0] lreg;
        logic [PW-1:0] preg;
        logic [PW-1:0] ppreg;
        logic          valid;
        logic          done;
    } rob_entry_s;

endpackage

// File: rtl/rob_ptr_adv.sv
// Advances a ROB pointer by 0..INSTR_COUNT, wrapping at ROB_DEPTH rather than 2^IW.
module rob_ptr_adv
    import rr_pkg::*;
(
    input  logic [IW-1:0] ptr,
    input  logic [CW-1:0] n,
    output logic [IW-1:0] res
);

    logic [IW:0] sum;

    always_comb begin
        sum = {1'b0, ptr} + {{(IW + 1 - CW){1'b0}}, n};
        if (sum >= (IW + 1)'(ROB_DEPTH)) begin
            res = rob_id_t'(sum - (IW + 1)'(ROB_DEPTH));
        end else begin
            res = sum[IW-1:0];
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates renamed instructions, marks writebacks done and
// retires up to INSTR_COUNT completed entries per cycle in program order.
module rob_commit_unit
    import rr_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    input  logic [INSTR_COUNT-1:0]    alloc_en,
    input  logic [INSTR_COUNT*LW-1:0] alloc_lreg,
    input  logic [INSTR_COUNT*PW-1:0] alloc_preg,
    input  logic [INSTR_COUNT*PW-1:0] alloc_ppreg,
    output logic                      alloc_ready,
    output logic [INSTR_COUNT*IW-1:0] alloc_rob_id,
    input  logic [INSTR_COUNT-1:0]    wb_en,
    input  logic [INSTR_COUNT*IW-1:0] wb_rob_id,
    input  logic                      commit_stall,
    output logic [INSTR_COUNT-1:0]    commit_valid,
    output logic [INSTR_COUNT*LW-1:0] commit_lreg,
    output logic [INSTR_COUNT*PW-1:0] commit_preg,
    output logic [INSTR_COUNT*PW-1:0] commit_ppreg,
    output logic [INSTR_COUNT*IW-1:0] commit_rob_id,
    output logic [IW-1:0]             occupancy,
    output logic                      wb_error
);

    rob_entry_s entries_q [ROB_DEPTH];
    rob_entry_s entries_d [ROB_DEPTH];

    logic [IW-1:0] head_q, head_d, tail_q, tail_d, occ_q, occ_d;
    logic [IW-1:0] head_adv, tail_adv, wb_id;
    logic          wb_error_q, wb_error_d;
    logic          alloc_fire, commit_ok;
    cnt_t          n_alloc, n_commit;

    logic [IW-1:0] head_slot [INSTR_COUNT];
    logic [IW-1:0] tail_slot [INSTR_COUNT];

    for (genvar g = 0; g < INSTR_COUNT; g++) begin : g_slot
        rob_ptr_adv u_head_slot (.ptr(head_q), .n(cnt_t'(g)), .res(head_slot[g]));
        rob_ptr_adv u_tail_slot (.ptr(tail_q), .n(cnt_t'(g)), .res(tail_slot[g]));
    end

    rob_ptr_adv u_head_adv (.ptr(head_q), .n(n_commit), .res(head_adv));
    rob_ptr_adv u_tail_adv (.ptr(tail_q), .n(n_alloc),  .res(tail_adv));

    // Allocation side: readiness uses registered occupancy, so a freed entry is reusable next cycle.
    always_comb begin
        alloc_ready  = (IW'(ROB_DEPTH) - occ_q) >= IW'(INSTR_COUNT);
        alloc_fire   = alloc_valid && alloc_ready && !flush;
        n_alloc      = '0;
        alloc_rob_id = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            alloc_rob_id[i*IW +: IW] = tail_slot[i];
            if (alloc_fire) begin
                n_alloc = n_alloc + cnt_t'(alloc_en[i]);
            end
        end
    end

    // Commit side: retire a contiguous run of done entries starting at head.
    always_comb begin
        commit_valid  = '0;
        commit_lreg   = '0;
        commit_preg   = '0;
        commit_ppreg  = '0;
        commit_rob_id = '0;
        n_commit      = '0;
        commit_ok     = !commit_stall && !flush;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            commit_ok = commit_ok && entries_q[head_slot[i]].valid && entries_q[head_slot[i]].done;
            commit_valid[i]           = commit_ok;
            commit_lreg[i*LW +: LW]   = entries_q[head_slot[i]].lreg;
            commit_preg[i*PW +: PW]   = entries_q[head_slot[i]].preg;
            commit_ppreg[i*PW +: PW]  = entries_q[head_slot[i]].ppreg;
            commit_rob_id[i*IW +: IW] = head_slot[i];
            if (commit_ok) begin
                n_commit = n_commit + cnt_t'(1);
            end
        end
    end

    always_comb begin
        entries_d  = entries_q;
        wb_error_d = wb_error_q;
        wb_id      = '0;
        head_d     = head_adv;
        tail_d     = tail_adv;
        occ_d      = occ_q + IW'(n_alloc) - IW'(n_commit);

        for (int i = 0; i < INSTR_COUNT; i++) begin
            if (commit_valid[i]) begin
                entries_d[head_slot[i]] = '0;
            end
        end

        // Validity is judged on registered state, so two ports naming one entry both succeed.
        for (int p = 0; p < INSTR_COUNT; p++) begin
            wb_id = wb_rob_id[p*IW +: IW];
            if (wb_en[p] && !flush) begin
                if (wb_id < IW'(ROB_DEPTH) && entries_q[wb_id].valid && !entries_q[wb_id].done) begin
                    entries_d[wb_id].done = 1'b1;
                end else begin
                    wb_error_d = 1'b1;
                end
            end
        end

        for (int i = 0; i < INSTR_COUNT; i++) begin
            if (alloc_fire && alloc_en[i]) begin
                entries_d[tail_slot[i]] = '{lreg:  alloc_lreg[i*LW +: LW],
                                            preg:  alloc_preg[i*PW +: PW],
                                            ppreg: alloc_ppreg[i*PW +: PW],
                                            valid: 1'b1,
                                            done:  1'b0};
            end
        end

        if (flush) begin
            for (int j = 0; j < ROB_DEPTH; j++) begin
                entries_d[j] = '0;
            end
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < ROB_DEPTH; j++) begin
                entries_q[j] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            wb_error_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            wb_error_q <= wb_error_d;
        end
    end

    assign occupancy = occ_q;
    assign wb_error  = wb_error_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed scenarios plus randomized traffic against a queue-based program-order model.
module tb_rob_commit_unit;
    import rr_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst, flush, alloc_valid, commit_stall, alloc_ready, wb_error;
    logic [INSTR_COUNT-1:0]    alloc_en, wb_en, commit_valid;
    logic [INSTR_COUNT*LW-1:0] alloc_lreg, commit_lreg;
    logic [INSTR_COUNT*PW-1:0] alloc_preg, alloc_ppreg, commit_preg, commit_ppreg;
    logic [INSTR_COUNT*IW-1:0] alloc_rob_id, wb_rob_id, commit_rob_id;
    logic [IW-1:0]             occupancy;

    always #5 clk = ~clk;

    rob_commit_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_en(alloc_en), .alloc_lreg(alloc_lreg),
        .alloc_preg(alloc_preg), .alloc_ppreg(alloc_ppreg), .alloc_ready(alloc_ready),
        .alloc_rob_id(alloc_rob_id), .wb_en(wb_en), .wb_rob_id(wb_rob_id),
        .commit_stall(commit_stall), .commit_valid(commit_valid), .commit_lreg(commit_lreg),
        .commit_preg(commit_preg), .commit_ppreg(commit_ppreg), .commit_rob_id(commit_rob_id),
        .occupancy(occupancy), .wb_error(wb_error)
    );

    typedef struct {
        int id;
        int lreg;
        int preg;
        int ppreg;
        bit done;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    bit   m_err;
    int   checks   = 0;
    int   failures = 0;

    function automatic int exp_commit_n();
        int n = 0;
        if (commit_stall || flush) return 0;
        for (int i = 0; i < INSTR_COUNT && i < q.size(); i++) begin
            if (!q[i].done) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit exp_ready();
        return (int'(ROB_DEPTH) - q.size()) >= int'(INSTR_COUNT);
    endfunction

    task automatic drive_idle();
        rst = 0; flush = 0; alloc_valid = 0; alloc_en = '0; commit_stall = 0; wb_en = '0;
        alloc_lreg = '0; alloc_preg = '0; alloc_ppreg = '0; wb_rob_id = '0;
    endtask

    task automatic rand_fields();
        alloc_lreg  = LW'($urandom) | (LW'($urandom) << LW);
        alloc_preg  = {PW'($urandom), PW'($urandom)};
        alloc_ppreg = {PW'($urandom), PW'($urandom)};
    endtask

    // One clock edge; the model consumes the inputs that were stable across that edge.
    task automatic tick();
        int nc, id;
        bit rdy;
        int idx [INSTR_COUNT];
        @(posedge clk);
        if (rst) begin
            q.delete(); m_tail = 0; m_err = 0;
        end else if (flush) begin
            q.delete(); m_tail = 0;
        end else begin
            nc  = exp_commit_n();
            rdy = exp_ready();
            for (int p = 0; p < INSTR_COUNT; p++) begin
                idx[p] = -1;
                if (wb_en[p]) begin
                    id = int'(wb_rob_id[p*IW +: IW]);
                    for (int k = 0; k < q.size(); k++)
                        if (q[k].id == id && !q[k].done) idx[p] = k;
                    if (idx[p] < 0) m_err = 1;
                end
            end
            for (int p = 0; p < INSTR_COUNT; p++)
                if (idx[p] >= 0) q[idx[p]].done = 1;
            for (int i = 0; i < nc; i++) void'(q.pop_front());
            if (alloc_valid && rdy) begin
                for (int i = 0; i < INSTR_COUNT; i++) begin
                    if (alloc_en[i]) begin
                        q.push_back('{m_tail, int'(alloc_lreg[i*LW +: LW]),
                                      int'(alloc_preg[i*PW +: PW]),
                                      int'(alloc_ppreg[i*PW +: PW]), 1'b0});
                        m_tail = (m_tail + 1) % int'(ROB_DEPTH);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1; alloc_valid = 1; alloc_en = 2'b11; wb_en = 2'b11; rand_fields();
        tick(); tick();
        drive_idle(); #1;
        checks++; if (occupancy !== 7'd0) begin failures++;
            $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (alloc_ready !== 1'b1) begin failures++;
            $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
        checks++; if (commit_valid !== 2'b00) begin failures++;
            $display("FAIL reset_commit_valid got=%b exp=00", commit_valid); end
        checks++; if (wb_error !== 1'b0) begin failures++;
            $display("FAIL reset_wb_error got=%b exp=0", wb_error); end
        checks++; if (alloc_rob_id !== {7'd1, 7'd0}) begin failures++;
            $display("FAIL reset_rob_ids got=%h exp=%h", alloc_rob_id, {7'd1, 7'd0}); end
    endtask

    task automatic test_basic();
        drive_idle();
        alloc_valid = 1; alloc_en = 2'b11;
        alloc_lreg = {5'd4, 5'd3}; alloc_preg = {6'd41, 6'd40}; alloc_ppreg = {6'd4, 6'd3};
        #1;
        checks++; if (alloc_rob_id !== {7'd1, 7'd0}) begin failures++;
            $display("FAIL basic_rob_ids got=%h exp=%h", alloc_rob_id, {7'd1, 7'd0}); end
        tick(); drive_idle(); #1;
        checks++; if (occupancy !== 7'd2) begin failures++;
            $display("FAIL basic_occupancy got=%0d exp=2", occupancy); end
        wb_en = 2'b01; wb_rob_id = {7'd0, 7'd1};
        tick(); drive_idle(); #1;
        checks++; if (commit_valid !== 2'b00) begin failures++;
            $display("FAIL basic_no_commit got=%b exp=00", commit_valid); end
        wb_en = 2'b01; wb_rob_id = {7'd0, 7'd0};
        tick(); drive_idle(); #1;
        checks++; if (commit_valid !== 2'b11) begin failures++;
            $display("FAIL basic_commit_valid got=%b exp=11", commit_valid); end
        checks++; if (commit_ppreg !== {6'd4, 6'd3}) begin failures++;
            $display("FAIL basic_commit_ppreg got=%h exp=%h", commit_ppreg, {6'd4, 6'd3}); end
        checks++; if (commit_preg !== {6'd41, 6'd40} || commit_lreg !== {5'd4, 5'd3}) begin
            failures++;
            $display("FAIL basic_commit_regs got preg=%h lreg=%h", commit_preg, commit_lreg); end
        tick(); #1;
        checks++; if (occupancy !== 7'd0 || commit_valid !== 2'b00) begin failures++;
            $display("FAIL basic_drained got occ=%0d cv=%b exp occ=0 cv=00",
                     occupancy, commit_valid); end
    endtask

    task automatic test_fill_wrap();
        int e0, e1;
        while (q.size() < 94) begin
            drive_idle(); alloc_valid = 1; alloc_en = 2'b11; rand_fields(); #1;
            e0 = m_tail; e1 = (m_tail + 1) % int'(ROB_DEPTH);
            checks++; if (alloc_rob_id !== {IW'(e1), IW'(e0)}) begin failures++;
                $display("FAIL fill_rob_ids got=%h exp=%0d,%0d", alloc_rob_id, e1, e0); end
            tick();
        end
        drive_idle(); alloc_valid = 1; alloc_en = 2'b01; rand_fields();
        tick(); drive_idle(); #1;
        checks++; if (occupancy !== 7'd95 || alloc_ready !== 1'b0) begin failures++;
            $display("FAIL fill_full got occ=%0d rdy=%b exp occ=95 rdy=0", occupancy, alloc_ready); end
        alloc_valid = 1; alloc_en = 2'b01; rand_fields();
        tick(); drive_idle(); #1;
        checks++; if (occupancy !== 7'd95) begin failures++;
            $display("FAIL fill_refuse_single got=%0d exp=95", occupancy); end
        wb_en = 2'b01; wb_rob_id[IW-1:0] = IW'(q[0].id);
        tick(); drive_idle(); #1;
        checks++; if (commit_valid !== 2'b01 || alloc_ready !== 1'b0) begin failures++;
            $display("FAIL fill_commit1 got cv=%b rdy=%b exp cv=01 rdy=0", commit_valid, alloc_ready); end
        tick(); #1;
        checks++; if (occupancy !== 7'd94 || alloc_ready !== 1'b1) begin failures++;
            $display("FAIL fill_reopen got occ=%0d rdy=%b exp occ=94 rdy=1", occupancy, alloc_ready); end
        wb_en = 2'b11; wb_rob_id = {IW'(q[1].id), IW'(q[0].id)};
        tick(); drive_idle();
        alloc_valid = 1; alloc_en = 2'b11; rand_fields(); #1;
        e0 = m_tail; e1 = (m_tail + 1) % int'(ROB_DEPTH);
        checks++; if (commit_valid !== 2'b11) begin failures++;
            $display("FAIL full_swap_commit got=%b exp=11", commit_valid); end
        checks++; if (alloc_rob_id !== {IW'(e1), IW'(e0)}) begin failures++;
            $display("FAIL full_swap_ids got=%h exp=%0d,%0d", alloc_rob_id, e1, e0); end
        tick(); drive_idle(); #1;
        checks++; if (occupancy !== 7'd94) begin failures++;
            $display("FAIL full_swap_occ got=%0d exp=94", occupancy); end
    endtask

    task automatic test_stall();
        int occ0;
        drive_idle(); wb_en = 2'b01; wb_rob_id[IW-1:0] = IW'(q[0].id);
        tick(); drive_idle(); commit_stall = 1; #1;
        occ0 = q.size();
        checks++; if (commit_valid !== 2'b00) begin failures++;
            $display("FAIL stall_commit got=%b exp=00", commit_valid); end
        tick(); #1;
        checks++; if (occupancy !== IW'(occ0)) begin failures++;
            $display("FAIL stall_hold got=%0d exp=%0d", occupancy, occ0); end
        commit_stall = 0; #1;
        checks++; if (commit_valid !== 2'b01 || commit_rob_id[IW-1:0] !== IW'(q[0].id)) begin
            failures++;
            $display("FAIL stall_release got cv=%b id=%0d exp cv=01 id=%0d",
                     commit_valid, commit_rob_id[IW-1:0], q[0].id); end
        tick(); #1;
        checks++; if (occupancy !== IW'(occ0 - 1)) begin failures++;
            $display("FAIL stall_after got=%0d exp=%0d", occupancy, occ0 - 1); end
    endtask

    task automatic test_flush_error();
        drive_idle(); wb_en = 2'b01; wb_rob_id[IW-1:0] = IW'(q[0].id);
        tick(); drive_idle();
        flush = 1; alloc_valid = 1; alloc_en = 2'b11; rand_fields();
        wb_en = 2'b01; wb_rob_id[IW-1:0] = IW'(q[1].id); #1;
        checks++; if (commit_valid !== 2'b00) begin failures++;
            $display("FAIL flush_blocks_commit got=%b exp=00", commit_valid); end
        tick(); drive_idle(); #1;
        checks++; if (occupancy !== 7'd0 || alloc_ready !== 1'b1 || alloc_rob_id !== {7'd1, 7'd0})
        begin failures++;
            $display("FAIL flush_state got occ=%0d rdy=%b ids=%h", occupancy, alloc_ready, alloc_rob_id); end
        checks++; if (wb_error !== 1'b0) begin failures++;
            $display("FAIL flush_no_error got=%b exp=0", wb_error); end
        wb_en = 2'b01; wb_rob_id[IW-1:0] = 7'd50;
        tick(); drive_idle(); #1;
        checks++; if (wb_error !== 1'b1) begin failures++;
            $display("FAIL wb_empty_error got=%b exp=1", wb_error); end
        alloc_valid = 1; alloc_en = 2'b11; rand_fields();
        tick(); drive_idle(); flush = 1;
        tick(); drive_idle(); #1;
        checks++; if (occupancy !== 7'd0 || alloc_rob_id !== {7'd1, 7'd0} || wb_error !== 1'b1)
        begin failures++;
            $display("FAIL flush_midstream got occ=%0d ids=%h err=%b exp occ=0 ids=0100 err=1",
                     occupancy, alloc_rob_id, wb_error); end
    endtask

    task automatic test_wb_corner();
        drive_idle(); rst = 1; tick(); drive_idle();
        alloc_valid = 1; alloc_en = 2'b11; rand_fields();
        tick(); drive_idle();
        wb_en = 2'b11; wb_rob_id = {7'd0, 7'd0};
        tick(); drive_idle(); #1;
        checks++; if (wb_error !== 1'b0 || commit_valid !== 2'b01) begin failures++;
            $display("FAIL dup_wb got err=%b cv=%b exp err=0 cv=01", wb_error, commit_valid); end
        alloc_valid = 1; alloc_en = 2'b01; rand_fields();
        wb_en = 2'b01; wb_rob_id[IW-1:0] = IW'(m_tail);
        tick(); drive_idle(); #1;
        checks++; if (wb_error !== 1'b1) begin failures++;
            $display("FAIL wb_same_cycle_alloc got=%b exp=1", wb_error); end
    endtask

    task automatic test_random();
        int pend[$];
        int r, nc;
        logic [INSTR_COUNT-1:0] exp_cv;
        drive_idle(); rst = 1; tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_idle();
            rst          = ($urandom_range(599) == 0);
            flush        = ($urandom_range(149) == 0);
            commit_stall = ($urandom_range(4) == 0);
            alloc_valid  = ($urandom_range(2) != 0);
            r = $urandom_range(2);
            alloc_en     = (r == 0) ? 2'b01 : ((r == 1) ? 2'b11 : 2'b00);
            rand_fields();
            pend.delete();
            foreach (q[k]) if (!q[k].done) pend.push_back(q[k].id);
            for (int p = 0; p < INSTR_COUNT; p++) begin
                r = $urandom_range(99);
                if (r < 60 && pend.size() > 0) begin
                    wb_en[p] = 1; wb_rob_id[p*IW +: IW] = IW'(pend[$urandom_range(pend.size() - 1)]);
                end else if (r < 61) begin
                    wb_en[p] = 1; wb_rob_id[p*IW +: IW] = IW'($urandom_range(127));
                end
            end
            #1;
            nc = exp_commit_n();
            exp_cv = INSTR_COUNT'((1 << nc) - 1);
            checks++; if (occupancy !== IW'(q.size()) || alloc_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rnd_occ cyc=%0d got occ=%0d rdy=%b exp occ=%0d rdy=%b",
                         cyc, occupancy, alloc_ready, q.size(), exp_ready()); end
            checks++; if (alloc_rob_id !== {IW'((m_tail + 1) % int'(ROB_DEPTH)), IW'(m_tail)}) begin
                failures++;
                $display("FAIL rnd_alloc_id cyc=%0d got=%h exp tail=%0d", cyc, alloc_rob_id, m_tail); end
            checks++; if (wb_error !== m_err) begin failures++;
                $display("FAIL rnd_wb_error cyc=%0d got=%b exp=%b", cyc, wb_error, m_err); end
            checks++; if (commit_valid !== exp_cv) begin failures++;
                $display("FAIL rnd_commit_valid cyc=%0d got=%b exp=%b", cyc, commit_valid, exp_cv); end
            for (int i = 0; i < nc; i++) begin
                checks++;
                if (commit_rob_id[i*IW +: IW] !== IW'(q[i].id) ||
                    commit_lreg[i*LW +: LW] !== LW'(q[i].lreg) ||
                    commit_preg[i*PW +: PW] !== PW'(q[i].preg) ||
                    commit_ppreg[i*PW +: PW] !== PW'(q[i].ppreg)) begin
                    failures++;
                    $display("FAIL rnd_commit_data cyc=%0d slot=%0d got id=%0d l=%0d p=%0d pp=%0d exp id=%0d l=%0d p=%0d pp=%0d",
                             cyc, i, commit_rob_id[i*IW +: IW], commit_lreg[i*LW +: LW],
                             commit_preg[i*PW +: PW], commit_ppreg[i*PW +: PW],
                             q[i].id, q[i].lreg, q[i].preg, q[i].ppreg);
                end
            end
            tick();
        end
    endtask

    initial begin
        drive_idle();
        m_tail = 0; m_err = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill_wrap();
        test_stall();
        test_flush_error();
        test_wb_corner();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached without summary");
        $fatal(1);
    end

endmodule
